// File: rtl/snake_engine_if.sv
// Signal bundle between the snake game-logic stage, its button front end and
// the VGA renderer. The engine is the master; consumers use the slave view.
interface snake_engine_if #(
    parameter int MAX_SIZE = 100
);
    logic                    i_up;
    logic                    i_down;
    logic                    i_left;
    logic                    i_right;
    logic                    i_restart;
    logic [MAX_SIZE*6-1:0]   o_worm_x;
    logic [MAX_SIZE*6-1:0]   o_worm_y;
    logic [5:0]              o_item_x;
    logic [5:0]              o_item_y;
    logic [11:0]             o_size;
    logic                    o_game_over;

    modport master (
        input  i_up, i_down, i_left, i_right, i_restart,
        output o_worm_x, o_worm_y, o_item_x, o_item_y, o_size, o_game_over
    );

    modport slave (
        output i_up, i_down, i_left, i_right, i_restart,
        input  o_worm_x, o_worm_y, o_item_x, o_item_y, o_size, o_game_over
    );
endinterface

// File: rtl/snake_engine.sv
// Snake game logic on a 64x48 cell grid: owns body, heading, food and game-over
// state, and presents them as registered buses to the renderer.
module snake_engine #(
    parameter int MAX_SIZE  = 100,
    parameter int INIT_SIZE = 3,
    parameter int TICK_DIV  = 5000000
) (
    input  logic           i_Clk,
    input  logic           i_Rst_n,
    snake_engine_if.master bus
);
    localparam int              CNT_W       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [15:0]     LFSR_SEED   = 16'hACE1;
    localparam logic [11:0]     INIT_SIZE_C = 12'(INIT_SIZE);
    localparam logic [11:0]     MAX_SIZE_C  = 12'(MAX_SIZE);

    typedef enum logic [1:0] {ST_RUN, ST_MOVE, ST_PLACE, ST_GAME_OVER} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    logic [5:0]       worm_x_r [MAX_SIZE];
    logic [5:0]       worm_y_r [MAX_SIZE];
    logic [5:0]       item_x_r, item_y_r;
    logic [11:0]      size_r;
    logic             game_over_r;
    dir_t             dir_cur_r, dir_pend_r, req_dir_s;
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      lfsr_r;

    logic             req_valid_s, capture_s;
    logic [5:0]       new_x_s, new_y_s, cand_x_s, cand_y_s;
    logic             wall_hit_s, self_hit_s, eat_s, cand_hit_s, cand_ok_s;
    logic             do_shift_s, do_grow_s, do_place_s, do_restart_s;
    logic [MAX_SIZE*6-1:0] worm_x_s, worm_y_s;

    function automatic logic lfsr_fb(input logic [15:0] v);
        return v[15] ^ v[13] ^ v[12] ^ v[10];
    endfunction

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        logic r;
        case (a)
            DIR_UP:    r = (b == DIR_DOWN);
            DIR_DOWN:  r = (b == DIR_UP);
            DIR_LEFT:  r = (b == DIR_RIGHT);
            DIR_RIGHT: r = (b == DIR_LEFT);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] init_x(input int k);
        return (k < INIT_SIZE) ? 6'(32 - k) : 6'd0;
    endfunction

    function automatic logic [5:0] init_y(input int k);
        return (k < INIT_SIZE) ? 6'd24 : 6'd0;
    endfunction

    // Button decode with fixed priority up > down > left > right.
    always_comb begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_RIGHT;
        if (bus.i_up)         req_dir_s = DIR_UP;
        else if (bus.i_down)  req_dir_s = DIR_DOWN;
        else if (bus.i_left)  req_dir_s = DIR_LEFT;
        else if (bus.i_right) req_dir_s = DIR_RIGHT;
        else                  req_valid_s = 1'b0;
    end

    assign capture_s = req_valid_s && !is_opposite(req_dir_s, dir_cur_r) &&
                       (state_r != ST_GAME_OVER);

    // Candidate head cell one step along the pending heading.
    always_comb begin
        new_x_s = worm_x_r[0];
        new_y_s = worm_y_r[0];
        case (dir_pend_r)
            DIR_UP:   new_y_s = worm_y_r[0] - 6'd1;
            DIR_DOWN: new_y_s = worm_y_r[0] + 6'd1;
            DIR_LEFT: new_x_s = worm_x_r[0] - 6'd1;
            default:  new_x_s = worm_x_r[0] + 6'd1;
        endcase
    end

    assign wall_hit_s = (new_x_s == 6'd0) || (new_x_s == 6'd63) ||
                        (new_y_s == 6'd0) || (new_y_s == 6'd47);
    assign eat_s      = (new_x_s == item_x_r) && (new_y_s == item_y_r);
    assign cand_x_s   = lfsr_r[5:0];
    assign cand_y_s   = lfsr_r[11:6];

    // Body overlap searches; the tail slot is excluded from the self-hit test
    // because it vacates on the same move.
    always_comb begin
        self_hit_s = 1'b0;
        cand_hit_s = 1'b0;
        for (int j = 0; j < MAX_SIZE; j++) begin
            self_hit_s = self_hit_s | (((12'(j) + 12'd1) < size_r) &&
                         (worm_x_r[j] == new_x_s) && (worm_y_r[j] == new_y_s));
            cand_hit_s = cand_hit_s | ((12'(j) < size_r) &&
                         (worm_x_r[j] == cand_x_s) && (worm_y_r[j] == cand_y_s));
        end
    end

    assign cand_ok_s = (cand_x_s >= 6'd1) && (cand_x_s <= 6'd62) &&
                       (cand_y_s >= 6'd1) && (cand_y_s <= 6'd46) && !cand_hit_s;

    // Next-state logic and datapath strobes.
    always_comb begin
        state_nxt_s  = state_r;
        do_shift_s   = 1'b0;
        do_grow_s    = 1'b0;
        do_place_s   = 1'b0;
        do_restart_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (cnt_r == CNT_LAST) state_nxt_s = ST_MOVE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_MOVE: begin
                if (wall_hit_s || self_hit_s) begin
                    state_nxt_s = ST_GAME_OVER;
                end else begin
                    do_shift_s = 1'b1;
                    if (eat_s) begin
                        do_grow_s   = 1'b1;
                        state_nxt_s = ST_PLACE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_PLACE: begin
                if (cand_ok_s) begin
                    do_place_s  = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PLACE;
                end
            end
            ST_GAME_OVER: begin
                if (bus.i_restart) begin
                    do_restart_s = 1'b1;
                    state_nxt_s  = ST_RUN;
                end else begin
                    state_nxt_s  = ST_GAME_OVER;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state_r <= ST_RUN;
        else          state_r <= state_nxt_s;
    end

    // Movement tick counter, advancing only while running.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)                cnt_r <= '0;
        else if (do_restart_s)       cnt_r <= '0;
        else if (state_r == ST_RUN)  cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
    end

    // Free-running placement LFSR; deliberately not reloaded on restart.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) lfsr_r <= LFSR_SEED;
        else          lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
    end

    // Heading: pending request is latched continuously, committed on a move.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n || do_restart_s) begin
            dir_cur_r  <= DIR_RIGHT;
            dir_pend_r <= DIR_RIGHT;
        end else begin
            if (capture_s)  dir_pend_r <= req_dir_s;
            if (do_shift_s) dir_cur_r  <= dir_pend_r;
        end
    end

    // Body slots; only a committed move shifts them.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int k = 0; k < MAX_SIZE; k++) begin
                worm_x_r[k] <= init_x(k);
                worm_y_r[k] <= init_y(k);
            end
        end else if (do_restart_s) begin
            for (int k = 0; k < MAX_SIZE; k++) begin
                worm_x_r[k] <= init_x(k);
                worm_y_r[k] <= init_y(k);
            end
        end else if (do_shift_s) begin
            worm_x_r[0] <= new_x_s;
            worm_y_r[0] <= new_y_s;
            for (int k = 1; k < MAX_SIZE; k++) begin
                worm_x_r[k] <= worm_x_r[k-1];
                worm_y_r[k] <= worm_y_r[k-1];
            end
        end
    end

    // Length, food position and game-over flag.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            size_r      <= INIT_SIZE_C;
            item_x_r    <= 6'd48;
            item_y_r    <= 6'd24;
            game_over_r <= 1'b0;
        end else if (do_restart_s) begin
            size_r      <= INIT_SIZE_C;
            item_x_r    <= 6'd48;
            item_y_r    <= 6'd24;
            game_over_r <= 1'b0;
        end else begin
            if (do_grow_s && (size_r < MAX_SIZE_C)) size_r <= size_r + 12'd1;
            if (do_place_s) begin
                item_x_r <= cand_x_s;
                item_y_r <= cand_y_s;
            end
            game_over_r <= (state_nxt_s == ST_GAME_OVER);
        end
    end

    // Pack slot registers onto the renderer buses.
    always_comb begin
        worm_x_s = '0;
        worm_y_s = '0;
        for (int k = 0; k < MAX_SIZE; k++) begin
            worm_x_s[k*6 +: 6] = worm_x_r[k];
            worm_y_s[k*6 +: 6] = worm_y_r[k];
        end
    end

    assign bus.o_worm_x    = worm_x_s;
    assign bus.o_worm_y    = worm_y_s;
    assign bus.o_item_x    = item_x_r;
    assign bus.o_item_y    = item_y_r;
    assign bus.o_size      = size_r;
    assign bus.o_game_over = game_over_r;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: three instances cover the default game,
// self-collision with a longer start, and length saturation.
module tb_snake_engine;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   failures = 0;

    snake_engine_if #(.MAX_SIZE(100)) bus_a ();
    snake_engine_if #(.MAX_SIZE(100)) bus_b ();
    snake_engine_if #(.MAX_SIZE(4))   bus_c ();

    snake_engine #(.MAX_SIZE(100), .INIT_SIZE(3), .TICK_DIV(4)) dut_a (.i_Clk(clk), .i_Rst_n(rst_a), .bus(bus_a));
    snake_engine #(.MAX_SIZE(100), .INIT_SIZE(5), .TICK_DIV(4)) dut_b (.i_Clk(clk), .i_Rst_n(rst_b), .bus(bus_b));
    snake_engine #(.MAX_SIZE(4),   .INIT_SIZE(3), .TICK_DIV(4)) dut_c (.i_Clk(clk), .i_Rst_n(rst_c), .bus(bus_c));

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic [3:0] btn;   // {up, down, left, right}
        int       moves;
        int       hx, hy, size, go;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ax(input int j); return int'(bus_a.o_worm_x[j*6 +: 6]); endfunction
    function automatic int ay(input int j); return int'(bus_a.o_worm_y[j*6 +: 6]); endfunction
    function automatic int bx(input int j); return int'(bus_b.o_worm_x[j*6 +: 6]); endfunction
    function automatic int by(input int j); return int'(bus_b.o_worm_y[j*6 +: 6]); endfunction
    function automatic int cx(input int j); return int'(bus_c.o_worm_x[j*6 +: 6]); endfunction
    function automatic int cy(input int j); return int'(bus_c.o_worm_y[j*6 +: 6]); endfunction

    task automatic wait_move_a();
        int hx0 = ax(0);
        int hy0 = ay(0);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (ax(0) != hx0 || ay(0) != hy0 || bus_a.o_game_over) seen = 1'b1;
        end
        chk("a_move_seen", int'(seen), 1);
    endtask

    task automatic wait_move_c();
        int hx0 = cx(0);
        int hy0 = cy(0);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (cx(0) != hx0 || cy(0) != hy0 || bus_c.o_game_over) seen = 1'b1;
        end
        chk("c_move_seen", int'(seen), 1);
    endtask

    // Wait until the food is no longer under the head (placement finished).
    task automatic settle_a();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (int'(bus_a.o_item_x) != ax(0) || int'(bus_a.o_item_y) != ay(0)) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("a_place_done", int'(ok), 1);
    endtask

    task automatic settle_c();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (int'(bus_c.o_item_x) != cx(0) || int'(bus_c.o_item_y) != cy(0)) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("c_place_done", int'(ok), 1);
    endtask

    task automatic set_btn_a(input logic [3:0] b);
        {bus_a.i_up, bus_a.i_down, bus_a.i_left, bus_a.i_right} = b;
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            set_btn_a(vecs[r].btn);
            for (int m = 0; m < vecs[r].moves; m++) wait_move_a();
            chk({vecs[r].name, "_hx"},   ax(0), vecs[r].hx);
            chk({vecs[r].name, "_hy"},   ay(0), vecs[r].hy);
            chk({vecs[r].name, "_size"}, int'(bus_a.o_size), vecs[r].size);
            chk({vecs[r].name, "_go"},   int'(bus_a.o_game_over), vecs[r].go);
        end
        set_btn_a(4'b0000);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_h0x"}, ax(0), 32);
        chk({tag, "_h0y"}, ay(0), 24);
        chk({tag, "_s1x"}, ax(1), 31);
        chk({tag, "_s2x"}, ax(2), 30);
        chk({tag, "_s2y"}, ay(2), 24);
        chk({tag, "_s3x"}, ax(3), 0);
        chk({tag, "_size"}, int'(bus_a.o_size), 3);
        chk({tag, "_itx"}, int'(bus_a.o_item_x), 48);
        chk({tag, "_ity"}, int'(bus_a.o_item_y), 24);
        chk({tag, "_go"}, int'(bus_a.o_game_over), 0);
    endtask

    initial begin
        int exp_size, ix, iy, hit, eats, dir_c, nd, dx, dy;
        vecs[0] = '{"a_run_right",    4'b0000, 14, 47, 24, 3, 0};
        vecs[1] = '{"a_eat",          4'b0000, 1,  48, 24, 4, 0};
        vecs[2] = '{"a_rev_ignored",  4'b0010, 1,  33, 24, 3, 0};
        vecs[3] = '{"a_turn_up",      4'b1000, 1,  33, 23, 3, 0};
        vecs[4] = '{"a_keep_up",      4'b0000, 1,  33, 22, 3, 0};
        vecs[5] = '{"a_down_ignored", 4'b0100, 1,  33, 21, 3, 0};
        {bus_a.i_up, bus_a.i_down, bus_a.i_left, bus_a.i_right, bus_a.i_restart} = 5'b0;
        {bus_b.i_up, bus_b.i_down, bus_b.i_left, bus_b.i_right, bus_b.i_restart} = 5'b0;
        {bus_c.i_up, bus_c.i_down, bus_c.i_left, bus_c.i_right, bus_c.i_restart} = 5'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_a("a_rst");

        // First move lands exactly TICK_DIV+1 clocks after reset release.
        @(negedge clk); rst_a = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("a_pre_tick_hx", ax(0), 32);
        @(posedge clk); #1;
        chk("a_tick1_hx", ax(0), 33);
        chk("a_tick1_s2x", ax(2), 31);

        apply_rows(0, 1);
        chk("a_item_held_x", int'(bus_a.o_item_x), 48);
        chk("a_tail_s3x", ax(3), 45);
        chk("a_tail_s3y", ay(3), 24);
        settle_a();
        ix = int'(bus_a.o_item_x);
        iy = int'(bus_a.o_item_y);
        chk("a_item_x_range", int'(ix >= 1 && ix <= 62), 1);
        chk("a_item_y_range", int'(iy >= 1 && iy <= 46), 1);
        hit = 0;
        for (int j = 0; j < 4; j++) if (ax(j) == ix && ay(j) == iy) hit = 1;
        chk("a_item_off_body", hit, 0);
        chk("a_tail_kept_s3x", ax(3), 45);

        // Run into the right wall, counting any food that lies on row 24.
        exp_size = 4;
        for (int m = 0; m < 14; m++) begin
            settle_a();
            if (int'(bus_a.o_item_x) == ax(0) + 1 && int'(bus_a.o_item_y) == 24) exp_size++;
            wait_move_a();
        end
        chk("a_edge_hx", ax(0), 62);
        chk("a_edge_size", int'(bus_a.o_size), exp_size);
        chk("a_edge_go", int'(bus_a.o_game_over), 0);
        wait_move_a();
        chk("a_wall_go", int'(bus_a.o_game_over), 1);
        chk("a_wall_hx", ax(0), 62);
        repeat (15) @(posedge clk); #1;
        chk("a_frozen_go", int'(bus_a.o_game_over), 1);
        chk("a_frozen_hx", ax(0), 62);
        chk("a_frozen_hy", ay(0), 24);
        chk("a_frozen_size", int'(bus_a.o_size), exp_size);

        bus_a.i_restart = 1'b1;
        @(posedge clk); #1;
        bus_a.i_restart = 1'b0;
        chk_reset_a("a_restart");

        apply_rows(2, 5);
        bus_a.i_restart = 1'b1;
        @(posedge clk); #1;
        bus_a.i_restart = 1'b0;
        chk("a_run_restart_hy", ay(0), 21);
        chk("a_run_restart_go", int'(bus_a.o_game_over), 0);
        wait_move_a();
        chk("a_after_restart_hy", ay(0), 20);
        chk("a_after_restart_hx", ax(0), 33);

        // Next MOVE cycle starts 4 edges after a committed move; reset inside it.
        repeat (4) @(posedge clk);
        #2 rst_a = 1'b0;
        #1 chk_reset_a("a_async");
        @(negedge clk); rst_a = 1'b1;

        // Self collision: UP, LEFT, DOWN with a 5-long body.
        bus_b.i_up = 1'b1;
        @(negedge clk); rst_b = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("b_up_hy", by(0), 23);
        bus_b.i_up = 1'b0; bus_b.i_left = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("b_left_hx", bx(0), 31);
        bus_b.i_left = 1'b0; bus_b.i_down = 1'b1;
        repeat (5) @(posedge clk); #1;
        bus_b.i_down = 1'b0;
        chk("b_self_go", int'(bus_b.o_game_over), 1);
        chk("b_self_h0x", bx(0), 31);
        chk("b_self_h0y", by(0), 23);
        chk("b_self_s1x", bx(1), 32);
        chk("b_self_s1y", by(1), 23);
        chk("b_self_s3x", bx(3), 31);
        chk("b_self_s3y", by(3), 24);
        chk("b_self_s4x", bx(4), 30);
        chk("b_self_size", int'(bus_b.o_size), 5);

        // Steer toward food until two meals; length must clamp at MAX_SIZE=4.
        @(negedge clk); rst_c = 1'b1;
        #1;
        eats = 0;
        dir_c = 3;
        for (int m = 0; m < 300 && eats < 2; m++) begin
            settle_c();
            ix = int'(bus_c.o_item_x);
            iy = int'(bus_c.o_item_y);
            dx = ix - cx(0);
            dy = iy - cy(0);
            if (dx > 0 && dir_c != 2)      nd = 3;
            else if (dx < 0 && dir_c != 3) nd = 2;
            else if (dy > 0 && dir_c != 0) nd = 1;
            else if (dy < 0 && dir_c != 1) nd = 0;
            else if (dir_c >= 2)           nd = (cy(0) > 1) ? 0 : 1;
            else                           nd = (cx(0) > 1) ? 2 : 3;
            bus_c.i_up    = (nd == 0);
            bus_c.i_down  = (nd == 1);
            bus_c.i_left  = (nd == 2);
            bus_c.i_right = (nd == 3);
            wait_move_c();
            dir_c = nd;
            if (cx(0) == ix && cy(0) == iy) begin
                eats++;
                chk(eats == 1 ? "c_size_first_eat" : "c_size_second_eat", int'(bus_c.o_size), 4);
            end
        end
        chk("c_eats", eats, 2);
        chk("c_size_sat", int'(bus_c.o_size), 4);
        chk("c_go", int'(bus_c.o_game_over), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
